mw_pipe_skid: RTL and testbench

Parametrised memory-to-writeback pipeline stage with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a stall-cycle counter. It carries the MEM-stage control bits, destination register index and ALU result into the WB stage. Unlike a plain always-enabled pipeline register, it absorbs back-pressure from WB without losing or duplicating an instruction, and it keeps full throughput when WB is ready. It sits between the memory stage and the register-file write port.

---
 rtl/mw_pipe_skid_pkg.sv | 10 +
 rtl/mw_pipe_skid_buffer.sv | 53 +++++
 rtl/mw_pipe_skid.sv | 57 +++++
 tb/tb_mw_pipe_skid.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mw_pipe_skid_pkg.sv
// mw_pipe_pkg: shared types and default widths for the MEM->WB stage
package mw_pipe_pkg;
  typedef struct packed {
    logic pcload;
    logic regw;
    logic regmem;
  } ctrl_t;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF = 4;
endpackage

// File: rtl/mw_pipe_skid_buffer.sv
// skid_buffer: generic two-entry valid/ready skid buffer with synchronous flush
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_v,
  output logic         in_r,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  input  logic         out_r,
  output logic [W-1:0] out_d
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic accept, drain;
  assign in_r = ~skid_v_q;
  assign out_v = main_v_q;
  assign out_d = main_q;
  assign accept = in_v & ~skid_v_q & ~flush;
  assign drain = main_v_q & out_r;
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (~main_v_q | drain) begin
      main_v_d = skid_v_q | accept;
      skid_v_d = 1'b0;
      main_d = skid_v_q ? skid_q : accept ? in_d : main_q;
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d = in_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/mw_pipe_skid.sv
// mw_pipe_skid: MEM->WB pipeline stage with skid buffer, flush and stall counter
module mw_pipe_skid
  import mw_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_M,
  output logic              ready_M,
  input  logic              pcload_M,
  input  logic              regw_M,
  input  logic              regmem_M,
  input  logic [REG_W-1:0]  regScr_M,
  input  logic [DATA_W-1:0] ALUrslt_M,
  output logic              valid_W,
  input  logic              ready_W,
  output logic              pcload_W,
  output logic              regw_W,
  output logic              regmem_W,
  output logic [REG_W-1:0]  regScr_W,
  output logic [DATA_W-1:0] ALUrslt_W,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int W = $bits(ctrl_t) + REG_W + DATA_W;
  ctrl_t ctrl_in, ctrl_out;
  logic [W-1:0] out_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign ctrl_in = '{pcload: pcload_M, regw: regw_M, regmem: regmem_M};
  skid_buffer #(.W(W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .in_v  (valid_M),
    .in_r  (ready_M),
    .in_d  ({ctrl_in, regScr_M, ALUrslt_M}),
    .out_v (valid_W),
    .out_r (ready_W),
    .out_d (out_d)
  );
  assign {ctrl_out, regScr_W, ALUrslt_W} = out_d;
  // bubbles must never write the register file or redirect the PC
  assign pcload_W = ctrl_out.pcload & valid_W;
  assign regw_W = ctrl_out.regw & valid_W;
  assign regmem_W = ctrl_out.regmem & valid_W;
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    stall_cnt_d = (valid_W & ~ready_W & ~flush & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
endmodule

// File: tb/tb_mw_pipe_skid.sv
// tb_mw_pipe_skid: scoreboard bench for mw_pipe_skid with directed vectors
module tb_mw_pipe_skid;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, valid_M = 1'b0, ready_W = 1'b0;
  logic pcload_M = 1'b0, regw_M = 1'b0, regmem_M = 1'b0;
  logic [3:0] regScr_M = '0;
  logic [31:0] ALUrslt_M = '0;
  logic ready_M, valid_W, pcload_W, regw_W, regmem_W;
  logic [3:0] regScr_W;
  logic [31:0] ALUrslt_W;
  logic [15:0] stall_cnt;
  logic s_ready_M, s_valid_W, s_pcload_W, s_regw_W, s_regmem_W;
  logic [3:0] s_regScr_W;
  logic [31:0] s_ALUrslt_W;
  logic [2:0] s_stall_cnt;
  int tests = 0, fails = 0;
  logic [38:0] q[$];

  always #5 clk = ~clk;

  mw_pipe_skid dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(ready_M),
    .pcload_M(pcload_M), .regw_M(regw_M), .regmem_M(regmem_M), .regScr_M(regScr_M),
    .ALUrslt_M(ALUrslt_M), .valid_W(valid_W), .ready_W(ready_W), .pcload_W(pcload_W),
    .regw_W(regw_W), .regmem_W(regmem_W), .regScr_W(regScr_W), .ALUrslt_W(ALUrslt_W),
    .stall_cnt(stall_cnt)
  );

  mw_pipe_skid #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(s_ready_M),
    .pcload_M(pcload_M), .regw_M(regw_M), .regmem_M(regmem_M), .regScr_M(regScr_M),
    .ALUrslt_M(ALUrslt_M), .valid_W(s_valid_W), .ready_W(ready_W), .pcload_W(s_pcload_W),
    .regw_W(s_regw_W), .regmem_W(s_regmem_W), .regScr_W(s_regScr_W), .ALUrslt_W(s_ALUrslt_W),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one MEM beat; push expected WB payload when the beat is meant to be accepted
  task automatic beat(input logic [2:0] c, input logic [3:0] r, input logic [31:0] a, input bit exp_acc);
    valid_M = 1'b1;
    {pcload_M, regw_M, regmem_M} = c;
    regScr_M = r;
    ALUrslt_M = a;
    if (exp_acc) q.push_back({c, r, a});
  endtask

  always @(negedge clk) begin
    if (!rst && valid_W && ready_W) begin
      if (q.size() == 0) chk("sb_unexpected_beat", 1, 0);
      else chk("sb_beat", {pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W}, q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid_W", valid_W, 0);
    chk("rst_ready_M", ready_M, 1);
    chk("rst_outs", {pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W}, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    tick();
    // streaming at full rate
    ready_W = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(3'b010, 4'(3 + i), 32'h0000FFFF - 32'(i), 1'b1);
      @(negedge clk);
      chk("stream_ready_M", ready_M, 1);
      chk("stream_latency", valid_W, i > 0);
      tick();
    end
    valid_M = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", valid_W, 1);
    tick();
    @(negedge clk);
    chk("stream_end_valid", valid_W, 0);
    chk("stream_stall", stall_cnt, 0);
    // back-pressure into the skid
    beat(3'b011, 4'd3, 32'h11, 1'b1);
    tick();
    ready_W = 1'b0;
    beat(3'b110, 4'd4, 32'h22, 1'b1);
    @(negedge clk);
    chk("bp_ready_before", ready_M, 1);
    tick();
    valid_M = 1'b0;
    @(negedge clk);
    chk("bp_ready_M_low", ready_M, 0);
    chk("bp_main_reg", regScr_W, 3);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("bp_stall4", stall_cnt, 4);
    chk("bp_still_low", ready_M, 0);
    ready_W = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_reg", regScr_W, 4);
    chk("bp_ready_M_back", ready_M, 1);
    tick();
    @(negedge clk);
    chk("bp_drained", valid_W, 0);
    chk("bp_stall_hold", stall_cnt, 4);
    // flush with both entries full plus an incoming beat
    ready_W = 1'b0;
    beat(3'b111, 4'd7, 32'h77, 1'b1);
    tick();
    beat(3'b111, 4'd8, 32'h88, 1'b1);
    tick();
    beat(3'b111, 4'd9, 32'h99, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid_M = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_valid_W", valid_W, 0);
    chk("flush_ctrl", {pcload_W, regw_W, regmem_W}, 0);
    chk("flush_ready_M", ready_M, 1);
    chk("flush_stall", stall_cnt, 5);
    ready_W = 1'b1;
    beat(3'b100, 4'd10, 32'hA0, 1'b1);
    tick();
    // flush coinciding with a drain: the WB beat still completes
    flush = 1'b1;
    valid_M = 1'b0;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drain_empty", valid_W, 0);
    // bubble gating
    beat(3'b011, 4'd12, 32'hABCD, 1'b1);
    tick();
    valid_M = 1'b0;
    tick();
    @(negedge clk);
    chk("bubble_valid", valid_W, 0);
    chk("bubble_ctrl", {pcload_W, regw_W, regmem_W}, 0);
    chk("bubble_alu", ALUrslt_W, 32'hABCD);
    chk("bubble_reg", regScr_W, 12);
    // saturation and reset mid-stall
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("sat_rst_cnt", {stall_cnt, 13'b0, s_stall_cnt}, 0);
    ready_W = 1'b0;
    beat(3'b010, 4'd13, 32'hD, 1'b0);
    tick();
    valid_M = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("sat_cnt3", s_stall_cnt, 7);
    chk("sat_cnt16", stall_cnt, 10);
    chk("sat_valid", s_valid_W, 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_valid", valid_W, 0);
    chk("midrst_ready", ready_M, 1);
    chk("midrst_outs", {pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W}, 0);
    chk("midrst_stall", stall_cnt, 0);
    rst = 1'b0;
    tick();
    chk("sb_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
